// File: rtl/demux_stream_pkg.sv
// Shared encodings and default sizes for the demux_stream 1-to-2 stream demultiplexer.
package demux_stream_pkg;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register for demux_stream. It loads a beat, holds it until the
// consumer takes it, and reports when it can accept a new beat at the next edge.
module demux_slot
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             drain;

    // A load in the same cycle as a drain keeps the slot FULL with the new beat.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drain   = (state_q == FULL) && out_ready;
        free    = (state_q == EMPTY) || drain;
        if (load) begin
            state_d = FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demultiplexer: InSelector = 1 routes a beat to A, 0 to B.
// Define DEMUX_COUNT_EN to add per-output handshake counters ACount/BCount.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic             InSelector,
    input  logic [WIDTH-1:0] InData,
    output logic             AValid,
    input  logic             AReady,
    output logic [WIDTH-1:0] AData,
    output logic             BValid,
    input  logic             BReady,
    output logic [WIDTH-1:0] BData
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] ACount,
    output logic [CNT_W-1:0] BCount
`endif
);

    logic a_free;
    logic b_free;
    logic accept;
    logic a_load;
    logic b_load;

    // Only the targeted slot gates InReady, so a stalled slot never blocks the other one.
    always_comb begin
        InReady = (InSelector == SEL_A) ? a_free : b_free;
        accept  = InValid && InReady;
        a_load  = accept && (InSelector == SEL_A);
        b_load  = accept && (InSelector == SEL_B);
    end

    demux_slot #(.WIDTH(WIDTH)) u_slot_a (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (a_load),
        .load_data (InData),
        .out_ready (AReady),
        .out_valid (AValid),
        .out_data  (AData),
        .free      (a_free)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot_b (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (b_load),
        .load_data (InData),
        .out_ready (BReady),
        .out_valid (BValid),
        .out_data  (BData),
        .free      (b_free)
    );

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] a_count_q, a_count_d;
    logic [CNT_W-1:0] b_count_q, b_count_d;

    // Counters wrap naturally at 2**CNT_W.
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (AValid && AReady) begin
            a_count_d = a_count_q + 1'b1;
        end
        if (BValid && BReady) begin
            b_count_d = b_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign ACount = a_count_q;
    assign BCount = b_count_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the two output slots.
module tb_demux_stream;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             InValid;
    logic             InReady;
    logic             InSelector;
    logic [WIDTH-1:0] InData;
    logic             AValid;
    logic             AReady;
    logic [WIDTH-1:0] AData;
    logic             BValid;
    logic             BReady;
    logic [WIDTH-1:0] BData;
`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] ACount;
    logic [CNT_W-1:0] BCount;
`endif

    always #5 Clock = ~Clock;

    demux_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .InSelector (InSelector),
        .InData     (InData),
        .AValid     (AValid),
        .AReady     (AReady),
        .AData      (AData),
        .BValid     (BValid),
        .BReady     (BReady),
        .BData      (BData)
`ifdef DEMUX_COUNT_EN
        ,
        .ACount     (ACount),
        .BCount     (BCount)
`endif
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Reference model: beats currently held per output, last payload loaded, handshakes seen.
    logic [WIDTH-1:0] aQ[$];
    logic [WIDTH-1:0] bQ[$];
    logic [WIDTH-1:0] lastA = '0;
    logic [WIDTH-1:0] lastB = '0;
    int               cntA  = 0;
    int               cntB  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input bit sel, input logic [WIDTH-1:0] data,
                                 input bit aRdy, input bit bRdy);
        InValid    = valid;
        InSelector = sel;
        InData     = data;
        AReady     = aRdy;
        BReady     = bRdy;
        #1;
    endtask

    function automatic void modelReset();
        aQ.delete();
        bQ.delete();
        lastA = '0;
        lastB = '0;
        cntA  = 0;
        cntB  = 0;
    endfunction

    // Check outputs mid-cycle, advance the model over the coming edge, then step past it.
    task automatic runCycle();
        bit targetFree;
        @(negedge Clock);
        checkOutput("AValid", {31'b0, AValid}, {31'b0, aQ.size() != 0});
        checkOutput("BValid", {31'b0, BValid}, {31'b0, bQ.size() != 0});
        checkOutput("AData", AData, lastA);
        checkOutput("BData", BData, lastB);
`ifdef DEMUX_COUNT_EN
        checkOutput("ACount", {28'b0, ACount}, cntA % (1 << CNT_W));
        checkOutput("BCount", {28'b0, BCount}, cntB % (1 << CNT_W));
`endif
        if (InSelector) targetFree = (aQ.size() == 0) || AReady;
        else            targetFree = (bQ.size() == 0) || BReady;
        checkOutput("InReady", {31'b0, InReady}, {31'b0, targetFree});
        if (aQ.size() != 0 && AReady) begin
            void'(aQ.pop_front());
            cntA++;
        end
        if (bQ.size() != 0 && BReady) begin
            void'(bQ.pop_front());
            cntB++;
        end
        if (InValid && targetFree) begin
            if (InSelector) begin
                aQ.push_back(InData);
                lastA = InData;
            end else begin
                bQ.push_back(InData);
                lastB = InData;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_AValid", {31'b0, AValid}, 32'd0);
        checkOutput("reset_BValid", {31'b0, BValid}, 32'd0);
        checkOutput("reset_AData", AData, 32'd0);
        checkOutput("reset_BData", BData, 32'd0);
        checkOutput("reset_InReady", {31'b0, InReady}, 32'd1);
        #1 Reset = 1'b0;
        @(posedge Clock);
        #1;

        // Basic routing to A
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        runCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("route_AValid", {31'b0, AValid}, 32'd1);
        checkOutput("route_AData", AData, 32'hDEADBEEF);
        checkOutput("route_BValid", {31'b0, BValid}, 32'd0);
        runCycle();

        // Back-pressure on B must not block A
        applyStimulus(1'b1, 1'b0, 32'h000000B0, 1'b1, 1'b0);
        runCycle();
        applyStimulus(1'b1, 1'b0, 32'h000000B1, 1'b1, 1'b0);
        checkOutput("bp_InReady_1", {31'b0, InReady}, 32'd0);
        runCycle();
        checkOutput("bp_InReady_2", {31'b0, InReady}, 32'd0);
        runCycle();
        applyStimulus(1'b1, 1'b1, 32'h000000A5, 1'b1, 1'b0);
        checkOutput("bp_A_InReady", {31'b0, InReady}, 32'd1);
        runCycle();
        checkOutput("bp_AValid", {31'b0, AValid}, 32'd1);
        checkOutput("bp_AData", AData, 32'h000000A5);
        checkOutput("bp_BData_held", BData, 32'h000000B0);
        applyStimulus(1'b1, 1'b0, 32'h000000B1, 1'b1, 1'b1);
        runCycle();
        applyStimulus(1'b1, 1'b0, 32'h000000B2, 1'b1, 1'b1);
        runCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        runCycle();
        runCycle();

        // Full throughput on A
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, i, 1'b1, 1'b1);
            checkOutput("tp_InReady", {31'b0, InReady}, 32'd1);
            runCycle();
            checkOutput("tp_AData", AData, i);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        runCycle();

        // Simultaneous drain and reload on A
        applyStimulus(1'b1, 1'b1, 32'h1, 1'b0, 1'b1);
        runCycle();
        applyStimulus(1'b1, 1'b1, 32'h2, 1'b1, 1'b1);
        checkOutput("dr_InReady", {31'b0, InReady}, 32'd1);
        runCycle();
        checkOutput("dr_AValid", {31'b0, AValid}, 32'd1);
        checkOutput("dr_AData", AData, 32'h2);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        runCycle();

        // Asynchronous reset with both slots full
        applyStimulus(1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("arst_pre_AData", AData, 32'h11111111);
        checkOutput("arst_pre_BData", BData, 32'h22222222);
        #1 Reset = 1'b1;
        #1;
        checkOutput("arst_AValid", {31'b0, AValid}, 32'd0);
        checkOutput("arst_BValid", {31'b0, BValid}, 32'd0);
        checkOutput("arst_AData", AData, 32'd0);
        checkOutput("arst_BData", BData, 32'd0);
        modelReset();
        #1 Reset = 1'b0;
        @(posedge Clock);
        #1;

`ifdef DEMUX_COUNT_EN
        // 17 handshakes on B wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h100 + i, 1'b1, 1'b1);
            runCycle();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        runCycle();
        runCycle();
        checkOutput("wrap_BCount", {28'b0, BCount}, 32'd1);
        checkOutput("wrap_ACount", {28'b0, ACount}, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            runCycle();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered 1-to-2 stream demultiplexer. It routes each input beat to output A or output B according to a per-beat selector, with valid/ready flow control on every side.
- It is the routing counterpart of the team's 2:1 selector mux. Selector encoding is the same: 1 selects A, 0 selects B.
- It sits between a single result producer and two consumers, for example a writeback bus feeding two destination stages.
- Each output has a one-entry holding register, which decouples the consumers' timing.

Parameters:
- WIDTH, 32, data width of the input and of both outputs in bits
- CNT_W, 16, width of the optional beat counters; used only with DEMUX_COUNT_EN

Ports:
- Clock  input  1  single clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  input beat present
- InReady  output  1  block accepts the input beat this cycle
- InSelector  input  1  route for the current beat: 1 = A, 0 = B; sampled only on acceptance
- InData  input  WIDTH  input payload
- AValid  output  1  slot A holds a beat
- AReady  input  1  consumer A accepts this cycle
- AData  output  WIDTH  slot A payload
- BValid  output  1  slot B holds a beat
- BReady  input  1  consumer B accepts this cycle
- BData  output  WIDTH  slot B payload

Behaviour:
- Reset:
  - Asserting Reset clears AValid, BValid, AData and BData to 0 immediately, without waiting for a clock edge.
  - The reset value of InReady is combinational from the cleared slots.
  - Reset mid-operation discards held beats. No beat is replayed after reset.
- Slot state: each slot is a two-state FSM, EMPTY or FULL.
  - XValid = (state == FULL).
  - XData is registered and changes only when a new beat is loaded.
- Output handshake: slot X drains when XValid && XReady.
  - After draining, slot X goes to EMPTY, unless the same slot is reloaded in the same cycle.
- Input acceptance: the target slot is A when InSelector = 1, else B.
  - InReady = (target EMPTY) or (target draining this cycle).
  - InReady is combinational from InSelector, the slot states and the target consumer's XReady.
  - A beat is accepted when InValid && InReady.
- Load:
  - An accepted beat is captured into the target slot at the next edge, which sets that slot FULL.
  - Latency from input acceptance to XValid is exactly 1 cycle.
- Simultaneous drain and load on the same slot: the slot stays FULL and holds the new data, giving full throughput of 1 beat per cycle per slot.
- Independence: a stalled slot never blocks beats routed to the other slot. Drains on A and B may occur in the same cycle.
- Stability: while XValid && !XReady, XData and XValid hold unchanged.
- Ordering: beats to the same output leave in arrival order. There is no ordering guarantee between A and B.
- InValid low: there is no load; InSelector and InData are ignored.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - Adds two output ports, ACount and BCount, each CNT_W bits wide.
  - Each counter increments by 1 on every completed handshake on its own output.
  - On overflow the counter wraps to 0 (for CNT_W = 16, 16'hFFFF wraps to 16'h0000).
  - Both counters are asynchronously cleared to 0 by Reset.
- Not defined: the ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header:
  - SEL_A = 1'b1 and SEL_B = 1'b0.
  - Default WIDTH and CNT_W values.
  - Slot state encodings: EMPTY = 1'b0, FULL = 1'b1.
- Sub-module demux_slot:
  - A one-entry holding register with load/drain logic and the Clock/Reset inputs.
  - Exposes a free/draining indication for the InReady computation.
  - Instantiated twice, once for A and once for B.
- The top level holds target selection, InReady, and the optional counters.

Test Plan:
- Reset during activity: fill both slots with 32'h11111111 (A) and 32'h22222222 (B), assert Reset mid-cycle -> AValid and BValid drop to 0 before the next edge, and AData and BData read 0.
- Basic routing: InValid=1, InSelector=1, InData=32'hDEADBEEF with AReady=1 -> AValid=1 and AData=32'hDEADBEEF exactly 1 cycle later; BValid stays 0.
- Back-pressure isolation: hold BReady=0 and send 3 beats to B -> the first is held and InReady=0 for the next two. Meanwhile a beat 32'hA5 with InSelector=1 is accepted and appears on A.
- Full throughput: 8 back-to-back beats to A (values 0..7) with AReady=1 -> InReady stays 1 throughout, and AData shows 0..7 on consecutive cycles.
- Simultaneous drain and reload: slot A FULL with 32'h1, AReady=1, and a new beat 32'h2 to A in the same cycle -> next cycle AValid=1 and AData=32'h2, with no bubble and no loss.
- Counter wrap (DEMUX_COUNT_EN, CNT_W=4): 17 handshakes on B -> BCount reads 1, and ACount remains 0.
